// File: rtl/nrzi_serial_rx_pkg.sv
// -----------------------------------------------------------------------------
// nrzi_serial_rx_pkg
//   Shared constants for the NRZI serial link (receiver and matching
//   transmitter): state encodings, default sync byte and stuffing run length,
//   and the idle line level. Also the bundle of one-cycle receiver pulses.
// -----------------------------------------------------------------------------
package nrzi_serial_rx_pkg;

    // Line level while the link is idle and after every end-of-packet.
    localparam logic LINE_IDLE = 1'b1;

    // Receiver FSM encodings.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    // Link defaults shared with the transmitter.
    localparam int          SYNC_W        = 8;
    localparam logic [7:0]  SYNC_PAT_DEF  = 8'h80;
    localparam int          STUFF_LEN_DEF = 6;
    localparam int          DATA_W_DEF    = 8;

    // One-cycle status pulses produced by the receiver.
    typedef struct packed {
        logic frame_start;
        logic data_valid;
        logic frame_end;
        logic rx_err;
    } rx_pulses_t;

endpackage

// File: rtl/nrzi_bit_decode.sv
// -----------------------------------------------------------------------------
// nrzi_bit_decode
//   Turns raw NRZI line samples into decoded bits. No transition between two
//   consecutive samples decodes as 1, a transition decodes as 0.
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   line_in    in   raw line level, meaningful when bit_valid=1
//   bit_valid  in   sample strobe
//   line_eop   in   end-of-packet strobe; wins over a coincident bit_valid
//   dbit       out  decoded bit (combinational)
//   dbit_valid out  decoded bit is valid this cycle
// -----------------------------------------------------------------------------
module nrzi_bit_decode
    import nrzi_serial_rx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    input  logic bit_valid,
    input  logic line_eop,
    output logic dbit,
    output logic dbit_valid
);

    logic prev_line;

    // EOP returns the reference level to idle so the next packet decodes from
    // a known start; a bit coincident with EOP is ignored entirely.
    always_ff @(posedge clk) begin
        if (!rst_n || line_eop) begin
            prev_line <= LINE_IDLE;
        end else if (bit_valid) begin
            prev_line <= line_in;
        end
    end

    assign dbit       = ~(line_in ^ prev_line);
    assign dbit_valid = bit_valid & ~line_eop;

endmodule

// File: rtl/nrzi_serial_rx.sv
// -----------------------------------------------------------------------------
// nrzi_serial_rx
//   Receive end of the NRZI serial link. Hunts for the sync byte, removes
//   stuffed zeros and assembles LSB-first bytes. Bits arrive on bit_valid
//   strobes from an upstream sampler; no clock recovery happens here.
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous reset, active-low
//   line_in      in   raw NRZI line level, valid when bit_valid=1
//   bit_valid    in   one-cycle sample strobe
//   line_eop     in   one-cycle end-of-packet strobe
//   data_out     out  last completed byte, held until the next one
//   data_valid   out  pulse: data_out updated
//   frame_start  out  pulse: sync byte matched
//   frame_end    out  pulse: EOP accepted while receiving data
//   rx_err       out  pulse: stuffing violation or partial byte at EOP
// -----------------------------------------------------------------------------
module nrzi_serial_rx
    import nrzi_serial_rx_pkg::*;
#(
    parameter int               DATA_W    = DATA_W_DEF,
    parameter int               STUFF_LEN = STUFF_LEN_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_in,
    input  logic              bit_valid,
    input  logic              line_eop,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              rx_err
);

    localparam int BC_W = $clog2(DATA_W + 1);
    localparam int OC_W = $clog2(STUFF_LEN + 1);

    logic              dbit;
    logic              dbit_valid;
    logic [0:0]        state;
    logic [SYNC_W-1:0] hunt_sr;
    logic [DATA_W-1:0] shift_sr;
    logic [BC_W-1:0]   bit_cnt;
    logic [OC_W-1:0]   ones_cnt;
    rx_pulses_t        pulses;

    nrzi_bit_decode u_decode (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_in    (line_in),
        .bit_valid  (bit_valid),
        .line_eop   (line_eop),
        .dbit       (dbit),
        .dbit_valid (dbit_valid)
    );

    // Bits arrive LSB-first, so each new bit enters at the MSB.
    logic [SYNC_W-1:0] hunt_next;
    logic [DATA_W-1:0] shift_next;
    logic [BC_W-1:0]   bit_cnt_inc;
    logic              stuff_slot;

    assign hunt_next   = {dbit, hunt_sr[SYNC_W-1:1]};
    assign shift_next  = {dbit, shift_sr[DATA_W-1:1]};
    assign bit_cnt_inc = bit_cnt + BC_W'(1);
    assign stuff_slot  = (ones_cnt == OC_W'(STUFF_LEN));

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hunt_sr  <= '0;
            shift_sr <= '0;
            bit_cnt  <= '0;
            ones_cnt <= '0;
            data_out <= '0;
            pulses   <= '0;
        end else begin
            pulses <= '0;
            if (line_eop) begin
                hunt_sr <= '0;
                if (state == ST_DATA) begin
                    pulses.frame_end <= 1'b1;
                    pulses.rx_err    <= (bit_cnt != '0);
                    state            <= ST_IDLE;
                    shift_sr         <= '0;
                    bit_cnt          <= '0;
                    ones_cnt         <= '0;
                end
            end else if (dbit_valid) begin
                if (state == ST_IDLE) begin
                    hunt_sr <= hunt_next;
                    if (hunt_next == SYNC_PAT) begin
                        // The sync byte ends in a 1, which opens the run of ones.
                        state              <= ST_DATA;
                        pulses.frame_start <= 1'b1;
                        ones_cnt           <= OC_W'(1);
                        bit_cnt            <= '0;
                        shift_sr           <= '0;
                    end
                end else if (stuff_slot) begin
                    // This bit must be the stuffed zero; it carries no data.
                    if (dbit) begin
                        pulses.rx_err <= 1'b1;
                        state         <= ST_IDLE;
                        shift_sr      <= '0;
                        bit_cnt       <= '0;
                        ones_cnt      <= '0;
                    end else begin
                        ones_cnt <= '0;
                    end
                end else begin
                    if (!dbit) begin
                        ones_cnt <= '0;
                    end else if (ones_cnt != '1) begin
                        ones_cnt <= ones_cnt + OC_W'(1);
                    end
                    shift_sr <= shift_next;
                    if (bit_cnt_inc == BC_W'(DATA_W)) begin
                        data_out          <= shift_next;
                        pulses.data_valid <= 1'b1;
                        bit_cnt           <= '0;
                    end else begin
                        bit_cnt <= bit_cnt_inc;
                    end
                end
            end
        end
    end

    assign frame_start = pulses.frame_start;
    assign data_valid  = pulses.data_valid;
    assign frame_end   = pulses.frame_end;
    assign rx_err      = pulses.rx_err;

endmodule

// File: tb/tb_nrzi_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_nrzi_serial_rx
//   Drives an NRZI encoder model (with automatic zero stuffing) from decoded
//   bit lists, pushes the expected receiver pulses into a scoreboard queue and
//   compares them as the receiver produces them.
// -----------------------------------------------------------------------------
module tb_nrzi_serial_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line_in;
    logic       bit_valid;
    logic       line_eop;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_start;
    logic       frame_end;
    logic       rx_err;

    always #5 clk = ~clk;

    nrzi_serial_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_in     (line_in),
        .bit_valid   (bit_valid),
        .line_eop    (line_eop),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .rx_err      (rx_err)
    );

    typedef struct packed {
        logic       start;
        logic       dv;
        logic       fend;
        logic       err;
        logic [7:0] data;
    } evt_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    evt_t exp_q[$];
    int   dv_stamps[$];

    logic tx_line  = 1'b1;   // encoder model line level
    int   tx_ones  = 0;      // encoder model run of decoded ones

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic evt_t mk(input logic s, input logic d, input logic e,
                                input logic r, input logic [7:0] v);
        evt_t t;
        t.start = s; t.dv = d; t.fend = e; t.err = r; t.data = d ? v : 8'h00;
        return t;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard consumer: any pulse must match the oldest expected event.
    always @(negedge clk) begin
        if ((frame_start === 1'b1) || (data_valid === 1'b1) ||
            (frame_end === 1'b1) || (rx_err === 1'b1)) begin
            evt_t obs;
            obs = mk(frame_start, data_valid, frame_end, rx_err, data_out);
            if (data_valid === 1'b1) dv_stamps.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(obs), 32'h0);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                check("event", 32'(obs), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One decoded bit on the wire: 1 keeps the level, 0 toggles it.
    task automatic send_dbit(input logic b);
        tx_line   = b ? tx_line : ~tx_line;
        line_in   = tx_line;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_dbit(1'b0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        send_dbit(1'b1);
        tx_ones = 1;
    endtask

    task automatic send_data_bit(input logic b, input logic stuff);
        send_dbit(b);
        tx_ones = b ? tx_ones + 1 : 0;
        if (stuff && tx_ones == 6) begin
            send_dbit(1'b0);
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic [7:0] bits;
        bits = v;
        for (int i = 0; i < 7; i++) send_data_bit(bits[i], 1'b1);
        // Completion is known once the last data bit goes out; any stuffed
        // zero it triggers follows the data_valid pulse.
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, v));
        send_data_bit(bits[7], 1'b1);
    endtask

    // EOP, optionally with a coincident (ignored) bit strobe.
    task automatic send_eop(input logic in_frame, input logic partial, input logic with_bit);
        if (in_frame) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, partial, 8'h00));
        line_eop  = 1'b1;
        bit_valid = with_bit;
        line_in   = ~tx_line;
        tick();
        line_eop  = 1'b0;
        bit_valid = 1'b0;
        tx_line   = 1'b1;
        tx_ones   = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        line_in   = 1'b1;
        bit_valid = 1'b0;
        line_eop  = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_pulses", 32'({frame_start, data_valid, frame_end, rx_err}), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1. sync, 0xA5, EOP (with a coincident bit strobe that must be ignored)
        send_sync();
        send_byte(8'hA5);
        send_eop(1'b1, 1'b0, 1'b1);
        repeat (3) tick();

        // 2. sync, 0xFF with the mandatory stuffed zero after the 5th data one
        send_sync();
        send_byte(8'hFF);
        send_eop(1'b1, 1'b0, 1'b0);
        repeat (3) tick();

        // 3. sync, ones without stuffing: the 6th one lands on the stuff slot
        send_sync();
        for (int i = 0; i < 5; i++) send_data_bit(1'b1, 1'b0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        send_data_bit(1'b1, 1'b0);
        send_data_bit(1'b1, 1'b0);
        send_data_bit(1'b1, 1'b0);
        // Receiver is back in IDLE: this EOP must produce nothing.
        send_eop(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("hold_after_err", 32'(data_out), 32'hFF);

        // 4. sync, 0x3C, half a byte, EOP -> frame_end together with rx_err
        send_sync();
        send_byte(8'h3C);
        send_data_bit(1'b1, 1'b1);
        send_data_bit(1'b0, 1'b1);
        send_data_bit(1'b1, 1'b1);
        send_data_bit(1'b0, 1'b1);
        send_eop(1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        check("hold_after_partial", 32'(data_out), 32'h3C);

        // 5. reset mid-byte, then a fresh frame
        send_sync();
        send_data_bit(1'b1, 1'b1);
        send_data_bit(1'b0, 1'b1);
        send_data_bit(1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        tx_line = 1'b1;
        tx_ones = 0;
        @(negedge clk);
        check("reset_mid_frame_data_out", 32'(data_out), 32'h0);
        tick();
        send_sync();
        send_byte(8'h12);
        send_eop(1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check("data_out_after_reset_frame", 32'(data_out), 32'h12);

        // 6. back-to-back bytes with bit_valid every cycle
        dv_stamps.delete();
        send_sync();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h80);
        send_byte(8'hFE);
        send_eop(1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check("b2b_count", 32'(dv_stamps.size()), 32'd4);
        if (dv_stamps.size() == 4) begin
            check("b2b_gap0", 32'(dv_stamps[1] - dv_stamps[0]), 32'd8);
            check("b2b_gap1", 32'(dv_stamps[2] - dv_stamps[1]), 32'd8);
            // 0xFE carries one stuffed zero after its sixth one.
            check("b2b_gap2", 32'(dv_stamps[3] - dv_stamps[2]), 32'd9);
        end

        repeat (4) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
